// File: rtl/dispatch_queue.sv
// In-order dispatch queue between ID and the RS/LSB back end: allocates ROB tags, renames rd,
// snoops CDB buses for pending operands. Optional macro DISPATCH_BYPASS_EN enables empty-queue issue.
module dispatch_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CDB_N  = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [OP_W-1:0]           id_op,
    input  logic [DATA_W-1:0]         id_imm,
    input  logic [REG_W-1:0]          id_rd,
    input  logic [DATA_W-1:0]         id_pc,
    input  logic                      id_is_mem,
    input  logic                      id_wr_rd,
    input  logic                      id_rs1_busy,
    input  logic [DATA_W-1:0]         id_rs1_val,
    input  logic                      id_rs2_busy,
    input  logic [DATA_W-1:0]         id_rs2_val,
    input  logic                      rob_ready,
    input  logic [ROB_W-1:0]          rob_tag,
    output logic                      rob_alloc,
    output logic                      reg_wq_valid,
    output logic [REG_W-1:0]          reg_wq_rd,
    output logic [ROB_W-1:0]          reg_wq_tag,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]   cdb_value,
    output logic                      rs_valid,
    input  logic                      rs_ready,
    output logic                      lsb_valid,
    input  logic                      lsb_ready,
    output logic [OP_W-1:0]           dq_op,
    output logic [DATA_W-1:0]         dq_imm,
    output logic [REG_W-1:0]          dq_rd,
    output logic [ROB_W-1:0]          dq_tag,
    output logic [DATA_W-1:0]         dq_pc,
    output logic                      dq_qj,
    output logic [DATA_W-1:0]         dq_vj,
    output logic                      dq_qk,
    output logic [DATA_W-1:0]         dq_vk
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rd;
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] pc;
        logic              is_mem;
        logic              qj;
        logic [DATA_W-1:0] vj;
        logic              qk;
        logic [DATA_W-1:0] vk;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    entry_t in_c;
    entry_t head_c;
    entry_t out_c;
    logic   head_valid_c;
    logic   bypass_c;
    logic   en_c;
    logic   accept_c;
    logic   pop_c;
    logic   pop_q_c;
    logic   push_c;

    // Resolve one operand against the CDB; scanning downward lets the lowest bus index win.
    function automatic logic [DATA_W:0] snoop(input logic busy, input logic [DATA_W-1:0] val);
        logic [DATA_W:0] r;
        r = {busy, val};
        if (busy) begin
            for (int i = int'(CDB_N) - 1; i >= 0; i--) begin
                if (cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == val[ROB_W-1:0]))
                    r = {1'b0, cdb_value[i*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        {r.qj, r.vj} = snoop(e.qj, e.vj);
        {r.qk, r.vk} = snoop(e.qk, e.vk);
        return r;
    endfunction

    assign en_c     = rst_n & rdy_in & ~flush_in;
    assign id_ready = en_c & rob_ready & (count < CNT_W'(DEPTH));
    assign accept_c = id_valid & id_ready;

    always_comb begin
        in_c        = '0;
        in_c.op     = id_op;
        in_c.imm    = id_imm;
        in_c.rd     = id_rd;
        in_c.tag    = rob_tag;
        in_c.pc     = id_pc;
        in_c.is_mem = id_is_mem;
        {in_c.qj, in_c.vj} = snoop(id_rs1_busy, id_rs1_val);
        {in_c.qk, in_c.vk} = snoop(id_rs2_busy, id_rs2_val);
    end

    // Head selection; an empty queue may forward the incoming instruction when bypass is built in.
    always_comb begin
        head_c       = wake(mem[head]);
        head_valid_c = (count != '0);
        bypass_c     = 1'b0;
`ifdef DISPATCH_BYPASS_EN
        if ((count == '0) && accept_c) begin
            head_c       = in_c;
            head_valid_c = 1'b1;
            bypass_c     = 1'b1;
        end
`endif
    end

    assign out_c     = head_valid_c ? head_c : '0;
    assign rs_valid  = en_c & head_valid_c & ~out_c.is_mem;
    assign lsb_valid = en_c & head_valid_c & out_c.is_mem;
    assign pop_c     = (rs_valid & rs_ready) | (lsb_valid & lsb_ready);
    assign pop_q_c   = pop_c & ~bypass_c;
    assign push_c    = accept_c & ~(bypass_c & pop_c);

    assign rob_alloc    = accept_c;
    assign reg_wq_valid = accept_c & id_wr_rd & (id_rd != '0);
    assign reg_wq_rd    = reg_wq_valid ? id_rd : '0;
    assign reg_wq_tag   = reg_wq_valid ? rob_tag : '0;

    assign dq_op  = out_c.op;
    assign dq_imm = out_c.imm;
    assign dq_rd  = out_c.rd;
    assign dq_tag = out_c.tag;
    assign dq_pc  = out_c.pc;
    assign dq_qj  = out_c.qj;
    assign dq_vj  = out_c.vj;
    assign dq_qk  = out_c.qk;
    assign dq_vk  = out_c.vk;

    // Entry payloads carry no reset; occupancy is owned by count/pointers.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in) begin
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= wake(mem[i]);
            if (push_c)
                mem[tail] <= in_c;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop_q_c)
                    head <= head + PTR_W'(1);
                if (push_c)
                    tail <= tail + PTR_W'(1);
                count <= count + CNT_W'(push_c) - CNT_W'(pop_q_c);
            end
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dispatch_queue;
    logic        clk;
    logic        rst_n, rdy_in, flush_in;
    logic        id_valid, id_ready;
    logic [5:0]  id_op;
    logic [31:0] id_imm, id_pc;
    logic [4:0]  id_rd;
    logic        id_is_mem, id_wr_rd;
    logic        id_rs1_busy, id_rs2_busy;
    logic [31:0] id_rs1_val, id_rs2_val;
    logic        rob_ready;
    logic [3:0]  rob_tag;
    logic        rob_alloc, reg_wq_valid;
    logic [4:0]  reg_wq_rd;
    logic [3:0]  reg_wq_tag;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        rs_valid, rs_ready, lsb_valid, lsb_ready;
    logic [5:0]  dq_op;
    logic [31:0] dq_imm, dq_pc, dq_vj, dq_vk;
    logic [4:0]  dq_rd;
    logic [3:0]  dq_tag;
    logic        dq_qj, dq_qk;

    int total = 0;
    int bad = 0;

    dispatch_queue dut (
        .clk_in(clk), .rst_n(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op), .id_imm(id_imm),
        .id_rd(id_rd), .id_pc(id_pc), .id_is_mem(id_is_mem), .id_wr_rd(id_wr_rd),
        .id_rs1_busy(id_rs1_busy), .id_rs1_val(id_rs1_val),
        .id_rs2_busy(id_rs2_busy), .id_rs2_val(id_rs2_val),
        .rob_ready(rob_ready), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
        .reg_wq_valid(reg_wq_valid), .reg_wq_rd(reg_wq_rd), .reg_wq_tag(reg_wq_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .lsb_valid(lsb_valid), .lsb_ready(lsb_ready),
        .dq_op(dq_op), .dq_imm(dq_imm), .dq_rd(dq_rd), .dq_tag(dq_tag), .dq_pc(dq_pc),
        .dq_qj(dq_qj), .dq_vj(dq_vj), .dq_qk(dq_qk), .dq_vk(dq_vk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered list of waiting instructions.
    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] pc;
        logic        is_mem;
        logic        qj;
        logic [31:0] vj;
        logic        qk;
        logic [31:0] vk;
    } m_t;

    m_t q[$];
    m_t h, inc, z;
    bit hv, en, acc, byp, pop, exp_rs, exp_lsb, exp_idr, exp_wq;

    // Apply the first broadcast (lowest bus) that carries a pending operand's tag.
    function automatic m_t wake(input m_t e);
        m_t r;
        r = e;
        for (int i = 0; i < 2; i++) begin
            if (r.qj && cdb_valid[i] && cdb_tag[i*4 +: 4] == r.vj[3:0]) begin
                r.qj = 1'b0;
                r.vj = cdb_value[i*32 +: 32];
            end
            if (r.qk && cdb_valid[i] && cdb_tag[i*4 +: 4] == r.vk[3:0]) begin
                r.qk = 1'b0;
                r.vk = cdb_value[i*32 +: 32];
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        z = '{default: '0};
        if (!rst_n) q.delete();
        en      = rst_n && rdy_in && !flush_in;
        exp_idr = en && rob_ready && (q.size() < 4);
        acc     = id_valid && exp_idr;
        inc = '{op: id_op, imm: id_imm, rd: id_rd, tag: rob_tag, pc: id_pc, is_mem: id_is_mem,
                qj: id_rs1_busy, vj: id_rs1_val, qk: id_rs2_busy, vk: id_rs2_val};
        inc = wake(inc);
        hv  = q.size() > 0;
        h   = hv ? wake(q[0]) : z;
        byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
        if (!hv && acc) begin
            h = inc; hv = 1'b1; byp = 1'b1;
        end
`endif
        exp_rs  = en && hv && !h.is_mem;
        exp_lsb = en && hv && h.is_mem;
        exp_wq  = acc && id_wr_rd && (id_rd != 5'd0);
        chk("m_id_ready", id_ready, exp_idr);
        chk("m_rob_alloc", rob_alloc, acc);
        chk("m_wq_valid", reg_wq_valid, exp_wq);
        chk("m_wq_rd", reg_wq_rd, exp_wq ? id_rd : 5'd0);
        chk("m_wq_tag", reg_wq_tag, exp_wq ? rob_tag : 4'd0);
        chk("m_rs_valid", rs_valid, exp_rs);
        chk("m_lsb_valid", lsb_valid, exp_lsb);
        chk("m_dq_op", dq_op, h.op);
        chk("m_dq_imm", dq_imm, h.imm);
        chk("m_dq_rd", dq_rd, h.rd);
        chk("m_dq_tag", dq_tag, h.tag);
        chk("m_dq_pc", dq_pc, h.pc);
        chk("m_dq_j", {dq_qj, dq_vj}, {h.qj, h.vj});
        chk("m_dq_k", {dq_qk, dq_vk}, {h.qk, h.vk});
        if (rst_n && rdy_in) begin
            if (flush_in) q.delete();
            else begin
                foreach (q[i]) q[i] = wake(q[i]);
                pop = (exp_rs && rs_ready) || (exp_lsb && lsb_ready);
                if (pop && !byp) void'(q.pop_front());
                if (acc && !(byp && pop)) q.push_back(inc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_op = 0; id_imm = 0; id_rd = 0; id_pc = 0;
        id_is_mem = 0; id_wr_rd = 0; rob_tag = 0;
        id_rs1_busy = 0; id_rs1_val = 0; id_rs2_busy = 0; id_rs2_val = 0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [3:0] tag,
                        input logic mem, input logic wr);
        id_valid = 1; id_op = op; id_rd = rd; rob_tag = tag;
        id_imm = 32'h100 + 32'(tag); id_pc = 32'h1000 + 32'(tag) * 4;
        id_is_mem = mem; id_wr_rd = wr;
        id_rs1_busy = 0; id_rs1_val = 32'h50 + 32'(rd);
        id_rs2_busy = 0; id_rs2_val = 0;
    endtask

    initial begin
        rst_n = 0; rdy_in = 1; flush_in = 0; rob_ready = 1;
        rs_ready = 0; lsb_ready = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        idle_id();
        repeat (2) @(posedge clk);
        at_neg();
        chk("rst_id_ready", id_ready, 0);
        chk("rst_dq_pc", dq_pc, 0);
        tick();
        rst_n = 1;

        // First instruction: ADDI rd=5, tag 3
        send(6'h13, 5'd5, 4'd3, 0, 1);
        rs_ready = 1;
        at_neg();
        chk("t1_rob_alloc", rob_alloc, 1);
        chk("t1_wq_rd", reg_wq_rd, 5);
        chk("t1_wq_tag", reg_wq_tag, 3);
`ifndef DISPATCH_BYPASS_EN
        chk("t1_no_same_cycle_issue", rs_valid, 0);
`endif
        tick();
        idle_id();
        at_neg();
`ifndef DISPATCH_BYPASS_EN
        chk("t1_rs_valid", rs_valid, 1);
        chk("t1_dq_tag", dq_tag, 3);
`endif
        tick();

        // Fill to DEPTH with both readies low, then drain in order
        rs_ready = 0;
        for (int k = 0; k < 4; k++) begin
            send(6'h33, 5'(k + 1), 4'(8 + k), 0, 1);
            tick();
        end
        send(6'h33, 5'd9, 4'd12, 0, 1);
        at_neg();
        chk("full_id_ready", id_ready, 0);
        tick();
        idle_id();
        rs_ready = 1;
        at_neg();
        chk("drain_first_tag", dq_tag, 8);
        repeat (4) tick();
        at_neg();
        chk("drained_empty", rs_valid, 0);
        tick();
        rs_ready = 0;

        // Snoop while waiting: rs1 tag 7 woken by bus 1
        send(6'h13, 5'd6, 4'd1, 0, 1);
        id_rs1_busy = 1; id_rs1_val = 32'd7;
        tick();
        idle_id();
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0}; cdb_value = {32'hDEADBEEF, 32'h0};
        tick();
        cdb_valid = 0;
        at_neg();
        chk("snoop_qj", dq_qj, 0);
        chk("snoop_vj", dq_vj, 32'hDEADBEEF);
        tick();
        rs_ready = 1;
        tick();
        rs_ready = 0;

        // Broadcast arriving in the issue cycle itself
        send(6'h13, 5'd7, 4'd2, 0, 1);
        id_rs1_busy = 1; id_rs1_val = 32'd7;
        tick();
        idle_id();
        rs_ready = 1;
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0}; cdb_value = {32'hDEADBEEF, 32'h0};
        at_neg();
        chk("issue_wake_rs_valid", rs_valid, 1);
        chk("issue_wake_qj", dq_qj, 0);
        chk("issue_wake_vj", dq_vj, 32'hDEADBEEF);
        tick();
        rs_ready = 0; cdb_valid = 0;

        // Two buses matching: bus 0 wins
        send(6'h13, 5'd8, 4'd4, 0, 1);
        id_rs2_busy = 1; id_rs2_val = 32'd2;
        tick();
        idle_id();
        rs_ready = 1;
        cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_value = {32'h222, 32'h111};
        at_neg();
        chk("low_bus_wins_vk", dq_vk, 32'h111);
        chk("low_bus_wins_qk", dq_qk, 0);
        tick();
        rs_ready = 0; cdb_valid = 0;

        // Wakeup at enqueue
        send(6'h13, 5'd9, 4'd5, 0, 1);
        id_rs1_busy = 1; id_rs1_val = 32'd5;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_value = {32'h0, 32'hABC};
        tick();
        idle_id();
        cdb_valid = 0;
        rs_ready = 1;
        at_neg();
        chk("enq_bypass_qj", dq_qj, 0);
        chk("enq_bypass_vj", dq_vj, 32'hABC);
        tick();
        rs_ready = 0;

        // Store goes to LSB without rename; rd=0 never renames
        lsb_ready = 1;
        send(6'h23, 5'd3, 4'd6, 1, 0);
        at_neg();
        chk("store_no_rename", reg_wq_valid, 0);
        tick();
        send(6'h13, 5'd0, 4'd7, 0, 1);
        at_neg();
        chk("rd0_no_rename", reg_wq_valid, 0);
        chk("rd0_rob_alloc", rob_alloc, 1);
`ifndef DISPATCH_BYPASS_EN
        chk("store_lsb_valid", lsb_valid, 1);
        chk("store_rs_valid", rs_valid, 0);
`endif
        tick();
        idle_id();
        rs_ready = 1;
        repeat (2) tick();
        rs_ready = 0; lsb_ready = 0;

        // rdy_in low freezes everything
        send(6'h13, 5'd10, 4'd9, 0, 1);
        tick();
        send(6'h13, 5'd11, 4'd10, 0, 1);
        rdy_in = 0; rs_ready = 1;
        at_neg();
        chk("rdy_low_id_ready", id_ready, 0);
        chk("rdy_low_rs_valid", rs_valid, 0);
        tick();
        rdy_in = 1;
        idle_id();
        at_neg();
        chk("rdy_back_rs_valid", rs_valid, 1);
        chk("rdy_back_tag", dq_tag, 9);
        tick();
        rs_ready = 0;

        // Flush with three queued
        for (int k = 0; k < 3; k++) begin
            send(6'h13, 5'(12 + k), 4'(10 + k), 0, 1);
            tick();
        end
        idle_id();
        flush_in = 1;
        at_neg();
        chk("flush_rs_valid", rs_valid, 0);
        chk("flush_id_ready", id_ready, 0);
        tick();
        flush_in = 0;
        at_neg();
        chk("post_flush_empty", rs_valid, 0);
        chk("post_flush_id_ready", id_ready, 1);
        tick();
        send(6'h13, 5'd15, 4'd13, 0, 1);
        tick();
        idle_id();
        rs_ready = 1;
        at_neg();
        chk("post_flush_issue", rs_valid, 1);
        chk("post_flush_tag", dq_tag, 13);
        tick();
        rs_ready = 0;

        // Full queue, then asynchronous reset mid-cycle
        for (int k = 0; k < 4; k++) begin
            send(6'h13, 5'(16 + k), 4'((14 + k) % 16), 0, 1);
            tick();
        end
        idle_id();
        rs_ready = 1;
        #2 rst_n = 0;
        #1;
        chk("areset_id_ready", id_ready, 0);
        chk("areset_rs_valid", rs_valid, 0);
        chk("areset_dq_tag", dq_tag, 0);
        chk("areset_dq_op", dq_op, 0);
        tick();
        rst_n = 1;
        send(6'h13, 5'd1, 4'd1, 0, 1);
        tick();
        idle_id();
        at_neg();
        chk("post_reset_issue", rs_valid, 1);
        chk("post_reset_tag", dq_tag, 1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
